bcd_scan_driver: RTL and testbench

- Upstream feeder for the 4-digit multiplexed BCD 7-segment decoder stage.
- Accepts a binary value through a load handshake and converts it to four BCD digits with a sequential shift-add-3 (double-dabble) engine.
- Time-multiplexes the digits onto a shared 4-bit BCD bus with a one-hot active-high digit select.
- The decoder stage consumes digit_sel as its anode-select input and digit_bcd as its binary input.

---
 rtl/bcd_scan_driver_if.sv | 32 +++
 rtl/bcd_scan_driver.sv | 177 +++++++++++++++++
 tb/tb_bcd_scan_driver.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/bcd_scan_driver_if.sv
// Load handshake and scanned-digit bus between a value source, bcd_scan_driver
// and the downstream 7-segment decoder stage.
interface bcd_scan_driver_if #(
    parameter int BIN_W = 14
);
    logic [BIN_W-1:0] bin_in;
    logic             load;
    logic             busy;
    logic             done;
    logic [3:0]       digit_sel;
    logic [3:0]       digit_bcd;

    // Source side: offers values and watches the display outputs
    modport master (
        output bin_in,
        output load,
        input  busy,
        input  done,
        input  digit_sel,
        input  digit_bcd
    );

    // Driver side: converts captured values and scans the digits
    modport slave (
        input  bin_in,
        input  load,
        output busy,
        output done,
        output digit_sel,
        output digit_bcd
    );
endinterface

// File: rtl/bcd_scan_driver.sv
// Binary to 4-digit BCD converter (sequential double-dabble) with a multiplexed digit scan.
// Optional macro LEADING_ZERO_BLANK_EN drives 4'hF on leading zero digits (units never blanked).
module bcd_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int BIN_W       = 14
) (
    input  logic               clk,
    input  logic               rst,
    bcd_scan_driver_if.slave   bus
);

    localparam int CNT_W  = $clog2(REFRESH_DIV);
    localparam int SHC_W  = $clog2(BIN_W + 1);
    localparam int SH_W   = 16 + BIN_W;
    localparam int CMP_W  = (BIN_W > 14) ? BIN_W : 14;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t             state_r;
    logic [SH_W-1:0]    shreg_r;
    logic [SHC_W-1:0]   shift_cnt_r;
    logic               busy_r;
    logic               done_r;
    logic [15:0]        disp_r;
    logic [CNT_W-1:0]   refresh_cnt_r;
    logic [1:0]         idx_r;
    logic [3:0]         sel_r;

    logic [CMP_W-1:0]   bin_wide_s;
    logic [BIN_W-1:0]   load_val_s;
    logic [SH_W-1:0]    shreg_next_s;
    logic [3:0]         nibble_s;
    logic [3:0]         digit_bcd_s;

    // Add 3 to every BCD nibble that is 5 or more, ahead of the doubling shift
    function automatic logic [15:0] add3_nibbles(input logic [15:0] bcd);
        logic [15:0] res;
        res = bcd;
        for (int k = 0; k < 4; k++) begin
            if (bcd[k*4 +: 4] >= 4'd5) begin
                res[k*4 +: 4] = bcd[k*4 +: 4] + 4'd3;
            end else begin
                res[k*4 +: 4] = bcd[k*4 +: 4];
            end
        end
        return res;
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    logic [2:0] blank_r;

    // Blank flags for thousands/hundreds/tens: a digit blanks only when every digit left of it is also zero
    function automatic logic [2:0] leading_zero_flags(input logic [15:0] bcd);
        logic b3;
        logic b2;
        logic b1;
        b3 = (bcd[15:12] == 4'd0);
        b2 = b3 && (bcd[11:8] == 4'd0);
        b1 = b2 && (bcd[7:4] == 4'd0);
        return {b3, b2, b1};
    endfunction
`endif

    // Saturate the captured value at 9999 so four digits always suffice
    always_comb begin
        bin_wide_s = CMP_W'(bus.bin_in);
        load_val_s = bus.bin_in;
        if (bin_wide_s > CMP_W'(32'd9999)) begin
            load_val_s = BIN_W'(32'd9999);
        end else begin
            load_val_s = bus.bin_in;
        end
    end

    // One double-dabble step: adjust the BCD field, then shift {bcd,bin} left by one
    always_comb begin
        shreg_next_s = {add3_nibbles(shreg_r[SH_W-1:BIN_W]), shreg_r[BIN_W-1:0]} << 1;
    end

    // Conversion FSM; the display register only ever takes a finished result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            shreg_r     <= {SH_W{1'b0}};
            shift_cnt_r <= {SHC_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            disp_r      <= 16'h0000;
`ifdef LEADING_ZERO_BLANK_EN
            blank_r     <= 3'b000;
`endif
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.load) begin
                        shreg_r     <= {16'h0000, load_val_s};
                        shift_cnt_r <= {SHC_W{1'b0}};
                        busy_r      <= 1'b1;
                        state_r     <= ST_SHIFT;
                    end else begin
                        busy_r      <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    shreg_r <= shreg_next_s;
                    if (shift_cnt_r == SHC_W'(BIN_W - 1)) begin
                        state_r <= ST_COMMIT;
                    end else begin
                        shift_cnt_r <= shift_cnt_r + SHC_W'(1);
                    end
                end
                ST_COMMIT: begin
                    disp_r  <= shreg_r[SH_W-1:BIN_W];
`ifdef LEADING_ZERO_BLANK_EN
                    blank_r <= leading_zero_flags(shreg_r[SH_W-1:BIN_W]);
`endif
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Free-running refresh counter and one-hot digit rotation, independent of conversion
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt_r <= {CNT_W{1'b0}};
            idx_r         <= 2'd0;
            sel_r         <= 4'b0001;
        end else if (refresh_cnt_r == CNT_W'(REFRESH_DIV - 1)) begin
            refresh_cnt_r <= {CNT_W{1'b0}};
            idx_r         <= idx_r + 2'd1;
            sel_r         <= {sel_r[2:0], sel_r[3]};
        end else begin
            refresh_cnt_r <= refresh_cnt_r + CNT_W'(1);
        end
    end

    // Nibble mux from registered index and display, so a commit and a digit advance land together
    always_comb begin
        nibble_s    = 4'd0;
        digit_bcd_s = 4'd0;
        case (idx_r)
            2'd0:    nibble_s = disp_r[3:0];
            2'd1:    nibble_s = disp_r[7:4];
            2'd2:    nibble_s = disp_r[11:8];
            2'd3:    nibble_s = disp_r[15:12];
            default: nibble_s = 4'd0;
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        case (idx_r)
            2'd1:    digit_bcd_s = blank_r[0] ? 4'hF : nibble_s;
            2'd2:    digit_bcd_s = blank_r[1] ? 4'hF : nibble_s;
            2'd3:    digit_bcd_s = blank_r[2] ? 4'hF : nibble_s;
            default: digit_bcd_s = nibble_s;
        endcase
`else
        digit_bcd_s = nibble_s;
`endif
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.digit_sel = sel_r;
    assign bus.digit_bcd = digit_bcd_s;

endmodule

// File: tb/tb_bcd_scan_driver.sv
// Scoreboard bench for bcd_scan_driver: accepted loads queue their expected value,
// each done pulse pops one and the scanned digits are compared against a decimal model.
module tb_bcd_scan_driver;

    localparam int REFRESH_DIV = 4;
    localparam int BIN_W       = 14;
    localparam int LATENCY     = BIN_W + 1;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bcd_scan_driver_if #(.BIN_W(BIN_W)) bus ();

    bcd_scan_driver #(
        .REFRESH_DIV (REFRESH_DIV),
        .BIN_W       (BIN_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int exp_q[$];

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic int model_digit(input int value, input int idx, input bit blank_ok);
        int d[4];
        bit all_zero;
        d[0] = value % 10;
        d[1] = (value / 10) % 10;
        d[2] = (value / 100) % 10;
        d[3] = (value / 1000) % 10;
        if (LZB && blank_ok && idx > 0) begin
            all_zero = 1'b1;
            for (int k = idx; k < 4; k++) if (d[k] != 0) all_zero = 1'b0;
            if (all_zero) return 15;
        end
        return d[idx];
    endfunction

    task automatic read_digits(input int value, input bit blank_ok, input string tag);
        int idx;
        for (int i = 0; i < 4 * REFRESH_DIV; i++) begin
            idx = (cyc / REFRESH_DIV) % 4;
            check_eq({tag, "_sel"}, int'(bus.digit_sel), 1 << idx);
            check_eq({tag, "_bcd"}, int'(bus.digit_bcd), model_digit(value, idx, blank_ok));
            tick();
        end
    endtask

    task automatic do_load(input int value);
        int k;
        k = 0;
        while (bus.busy && k < 50) begin
            tick();
            k++;
        end
        check_eq("load_wait_busy", int'(bus.busy), 0);
        bus.bin_in = BIN_W'(value);
        bus.load   = 1'b1;
        tick();
        bus.load   = 1'b0;
        check_eq("busy_after_load", int'(bus.busy), 1);
        exp_q.push_back((value > 9999) ? 9999 : value);
    endtask

    // Wait for done; optionally issue a second load at a given busy cycle
    task automatic wait_done(input string tag, input int inj_lat, input int inj_val);
        int lat;
        int busy_cnt;
        bit got;
        int exp_val;
        lat      = 0;
        busy_cnt = 1;
        got      = 1'b0;
        while (lat < 40 && !got) begin
            if (lat == inj_lat) begin
                bus.bin_in = BIN_W'(inj_val);
                bus.load   = 1'b1;
            end
            tick();
            bus.load = 1'b0;
            lat++;
            if (bus.done) got = 1'b1;
            else if (bus.busy) busy_cnt++;
        end
        if (!got) begin
            check_eq({tag, "_done_timeout"}, 0, 1);
        end else begin
            check_eq({tag, "_latency"}, lat, LATENCY);
            check_eq({tag, "_busy_cycles"}, busy_cnt, LATENCY);
            check_eq({tag, "_busy_at_done"}, int'(bus.busy), 0);
            if (exp_q.size() == 0) begin
                check_eq({tag, "_queue_empty"}, 0, 1);
            end else begin
                exp_val = exp_q.pop_front();
                read_digits(exp_val, 1'b1, tag);
            end
            check_eq({tag, "_done_low"}, int'(bus.done), 0);
        end
    endtask

    task automatic apply_reset(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) tick();
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        int dones;
        bus.bin_in = '0;
        bus.load   = 1'b0;

        apply_reset(3);
        check_eq("rst_busy", int'(bus.busy), 0);
        check_eq("rst_done", int'(bus.done), 0);
        read_digits(0, 1'b0, "rst_scan");
        check_eq("rst_wrap_sel", int'(bus.digit_sel), 1 << ((cyc / REFRESH_DIV) % 4));

        do_load(1234);
        wait_done("v1234", -1, 0);

        do_load(16383);
        wait_done("sat", -1, 0);

        do_load(42);
        wait_done("drop", 2, 7);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.done) dones++;
        end
        check_eq("drop_extra_done", dones, 0);
        check_eq("drop_queue", exp_q.size(), 0);
        read_digits(42, 1'b1, "drop_hold");

        do_load(9876);
        for (int i = 0; i < 5; i++) tick();
        apply_reset(1);
        exp_q.delete();
        check_eq("abort_busy", int'(bus.busy), 0);
        check_eq("abort_done", int'(bus.done), 0);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.done) dones++;
        end
        check_eq("abort_no_done", dones, 0);
        read_digits(0, 1'b0, "abort_disp");

        do_load(5);
        wait_done("v5", -1, 0);
        do_load(7);
        wait_done("v7", -1, 0);
        do_load(0);
        wait_done("v0", -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
